// File: rtl/anf_fl_tex_etc2_fetch_ctrl_pkg.sv
// Shared definitions for the ETC2 fetch controller slice.
//   state_t   : controller FSM states
//   BLOCK_W   : compressed ETC2 block width in bits
//   TAG_LSB   : lowest block-address bit that takes part in the tag
//   packRgba  : packs decoder channels as {R,G,B,A}, with R in the MSBs
package anf_fl_tex_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MREQ   = 3'd1,
        ST_MWAIT  = 3'd2,
        ST_DECODE = 3'd3,
        ST_OUT    = 3'd4
    } state_t;

    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned TAG_LSB = 4;

    function automatic logic [31:0] packRgba(
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b,
        input logic [7:0] a
    );
        return {r, g, b, a};
    endfunction

endpackage

// File: rtl/anf_fl_tex_etc2_fetch_ctrl_if.sv
// Handshake bundle around the ETC2 fetch controller.
//   req_*     : texel lookup request (valid/ready, block address, format, x/y)
//   mem_req_* : block read request to memory (valid/ready, address)
//   mem_rsp_* : single-beat 128-bit block response
//   dec_*     : drive to / result from the external combinational decoder
//   out_*     : registered RGBA8 result (valid/ready)
// master = controller side, slave = surrounding environment.
interface anf_fl_tex_etc2_fetch_ctrl_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned FMT_W  = 5
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [FMT_W-1:0]  req_fmt;
    logic [1:0]        req_x;
    logic [1:0]        req_y;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_rsp_valid;
    logic [127:0]      mem_rsp_data;

    logic [127:0]      dec_data;
    logic [FMT_W-1:0]  dec_format;
    logic [1:0]        dec_x;
    logic [1:0]        dec_y;
    logic [7:0]        dec_r;
    logic [7:0]        dec_g;
    logic [7:0]        dec_b;
    logic [7:0]        dec_a;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_rgba;

    modport master (
        input  req_valid, req_addr, req_fmt, req_x, req_y,
        output req_ready,
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output dec_data, dec_format, dec_x, dec_y,
        input  dec_r, dec_g, dec_b, dec_a,
        output out_valid, out_rgba,
        input  out_ready
    );

    modport slave (
        output req_valid, req_addr, req_fmt, req_x, req_y,
        input  req_ready,
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  dec_data, dec_format, dec_x, dec_y,
        output dec_r, dec_g, dec_b, dec_a,
        input  out_valid, out_rgba,
        output out_ready
    );
endinterface

// File: rtl/anf_fl_tex_etc2_fetch_ctrl_sat_counter.sv
// Saturating up-counter used for the hit/miss performance counters.
//   clk   : clock
//   clear : synchronous clear to zero (highest priority)
//   inc   : increment by one unless already all-ones
//   cnt   : current count
module anf_fl_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/anf_fl_tex_etc2_fetch_ctrl.sv
// ETC2 block fetch sequencer in front of the external block decoder.
// Holds a single tagged 128-bit block buffer; a lookup that hits decodes
// straight from the buffer, a miss fetches the block from memory first.
// One transaction is in flight at a time; results are registered RGBA8.
//   clk, rst_n : clock, synchronous active-low reset
//   inval      : invalidate the block buffer at the next clock edge
//   bus        : request / memory / decoder / result handshakes (master view)
//   hit_cnt    : saturating count of accepted lookups that hit
//   miss_cnt   : saturating count of accepted lookups that missed
module anf_fl_tex_etc2_fetch_ctrl
    import anf_fl_tex_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned FMT_W  = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          inval,
    anf_fl_tex_etc2_fetch_ctrl_if.master  bus,
    output logic [CNT_W-1:0]              hit_cnt,
    output logic [CNT_W-1:0]              miss_cnt
);

    localparam int unsigned BASE_W = ADDR_W - TAG_LSB;
    localparam int unsigned TAG_W  = BASE_W + FMT_W;

    state_t              state;
    state_t              nextState;

    logic [BASE_W-1:0]   baseQ;
    logic [FMT_W-1:0]    fmtQ;
    logic [1:0]          xQ;
    logic [1:0]          yQ;
    logic [BLOCK_W-1:0]  blkBuf;
    logic [TAG_W-1:0]    tagQ;
    logic                tagValid;
    logic                invalPend;
    logic [31:0]         rgbaQ;

    logic [TAG_W-1:0]    reqTag;
    logic                hit;
    logic                accept;
    logic                rspTake;
    logic                hitInc;
    logic                missInc;
    logic                unusedAddrBits;

    assign reqTag         = {bus.req_addr[ADDR_W-1:TAG_LSB], bus.req_fmt};
    assign hit            = tagValid && (reqTag == tagQ);
    assign accept         = (state == ST_IDLE) && bus.req_valid;
    assign rspTake        = (state == ST_MWAIT) && bus.mem_rsp_valid;
    assign unusedAddrBits = ^bus.req_addr[TAG_LSB-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:   if (bus.req_valid)     nextState = hit ? ST_DECODE : ST_MREQ;
            ST_MREQ:   if (bus.mem_req_ready) nextState = ST_MWAIT;
            ST_MWAIT:  if (bus.mem_rsp_valid) nextState = ST_DECODE;
            ST_DECODE:                        nextState = ST_OUT;
            ST_OUT:    if (bus.out_ready)     nextState = ST_IDLE;
            default:                          nextState = ST_IDLE;
        endcase
    end

    // Output logic; req_ready is gated by rst_n so it stays low while reset is held
    always_comb begin
        bus.req_ready     = rst_n && (state == ST_IDLE);
        bus.mem_req_valid = (state == ST_MREQ);
        bus.out_valid     = (state == ST_OUT);
        hitInc            = accept && hit;
        missInc           = accept && !hit;
    end

    // Datapath: latched request, block buffer, tag and result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baseQ     <= '0;
            fmtQ      <= '0;
            xQ        <= '0;
            yQ        <= '0;
            blkBuf    <= '0;
            tagQ      <= '0;
            tagValid  <= 1'b0;
            invalPend <= 1'b0;
            rgbaQ     <= '0;
        end else begin
            if (accept) begin
                baseQ <= bus.req_addr[ADDR_W-1:TAG_LSB];
                fmtQ  <= bus.req_fmt;
                xQ    <= bus.req_x;
                yQ    <= bus.req_y;
            end

            // An invalidate seen while a fetch is outstanding must still leave
            // the buffer invalid once the response lands, so remember it.
            if (state == ST_IDLE) begin
                invalPend <= 1'b0;
            end else if (inval && ((state == ST_MREQ) || (state == ST_MWAIT))) begin
                invalPend <= 1'b1;
            end

            if (rspTake) begin
                blkBuf   <= bus.mem_rsp_data;
                tagQ     <= {baseQ, fmtQ};
                tagValid <= !(inval || invalPend);
            end else if (inval || missInc) begin
                tagValid <= 1'b0;
            end

            if (state == ST_DECODE) begin
                rgbaQ <= packRgba(bus.dec_r, bus.dec_g, bus.dec_b, bus.dec_a);
            end
        end
    end

    assign bus.mem_req_addr = {baseQ, {TAG_LSB{1'b0}}};
    assign bus.dec_data     = blkBuf;
    assign bus.dec_format   = fmtQ;
    assign bus.dec_x        = xQ;
    assign bus.dec_y        = yQ;
    assign bus.out_rgba     = rgbaQ;

    anf_fl_sat_counter #(.CNT_W(CNT_W)) uHitCnt (
        .clk   (clk),
        .clear (~rst_n),
        .inc   (hitInc),
        .cnt   (hit_cnt)
    );

    anf_fl_sat_counter #(.CNT_W(CNT_W)) uMissCnt (
        .clk   (clk),
        .clear (~rst_n),
        .inc   (missInc),
        .cnt   (miss_cnt)
    );

endmodule

// File: tb/tb_anf_fl_tex_etc2_fetch_ctrl.sv
// Directed self-checking bench for anf_fl_tex_etc2_fetch_ctrl.
// A stand-in decoder returns, for texel index i = {y,x}:
//   R = block byte i, G = block byte 15-i, B = {3'b0,fmt}, A = {x,y,4'hA}
// CNT_W is reduced to 3 so counter saturation is reachable quickly.
module tb_anf_fl_tex_etc2_fetch_ctrl;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned FMT_W  = 5;
    localparam int unsigned CNT_W  = 3;

    localparam logic [127:0] BLK0 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] BLK1 = 128'hF0E0D0C0B0A090807060504030201000;

    logic             clk;
    logic             rst_n;
    logic             inval;
    logic [CNT_W-1:0] hitCnt;
    logic [CNT_W-1:0] missCnt;
    logic [3:0]       texIdx;

    int nTests;
    int nFail;

    anf_fl_tex_etc2_fetch_ctrl_if #(.ADDR_W(ADDR_W), .FMT_W(FMT_W)) bus ();

    anf_fl_tex_etc2_fetch_ctrl #(
        .ADDR_W (ADDR_W),
        .FMT_W  (FMT_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inval    (inval),
        .bus      (bus),
        .hit_cnt  (hitCnt),
        .miss_cnt (missCnt)
    );

    assign texIdx    = {bus.dec_y, bus.dec_x};
    assign bus.dec_r = bus.dec_data[texIdx*8 +: 8];
    assign bus.dec_g = bus.dec_data[(4'd15 - texIdx)*8 +: 8];
    assign bus.dec_b = {3'b000, bus.dec_format};
    assign bus.dec_a = {bus.dec_x, bus.dec_y, 4'hA};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] addr, input logic [4:0] fmt, input logic [1:0] x, input logic [1:0] y);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_fmt   = fmt;
        bus.req_x     = x;
        bus.req_y     = y;
    endtask

    initial begin
        nTests = 0;
        nFail  = 0;
        rst_n  = 1'b0;
        inval  = 1'b0;
        bus.req_valid     = 1'b0;
        bus.req_addr      = '0;
        bus.req_fmt       = '0;
        bus.req_x         = '0;
        bus.req_y         = '0;
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.out_ready     = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_mreq_valid", bus.mem_req_valid, 1'b0);
        check("rst_out_rgba", bus.out_rgba, 32'h0);
        check("rst_mreq_addr", bus.mem_req_addr, 32'h0);
        check("rst_dec_data", bus.dec_data, 128'h0);
        check("rst_hit", hitCnt, 3'd0);
        check("rst_miss", missCnt, 3'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", bus.req_ready, 1'b1);

        // Cold miss: 0x1000 fmt1 x2 y1, response 3 cycles after the request
        drive(32'h1000, 5'd1, 2'd2, 2'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("cold_mreq_valid", bus.mem_req_valid, 1'b1);
        check("cold_mreq_addr", bus.mem_req_addr, 32'h1000);
        check("cold_req_ready", bus.req_ready, 1'b0);
        check("cold_miss", missCnt, 3'd1);
        @(negedge clk);
        check("cold_mwait_mreq", bus.mem_req_valid, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = BLK0;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        check("cold_decode_ov", bus.out_valid, 1'b0);
        @(negedge clk);
        check("cold_out_valid", bus.out_valid, 1'b1);
        check("cold_rgba", bus.out_rgba, 32'h0609019A);
        check("cold_hit", hitCnt, 3'd0);
        @(negedge clk);
        check("cold_back_idle", bus.out_valid, 1'b0);
        check("cold_idle_ready", bus.req_ready, 1'b1);

        // Hit on the same block, low address bits differ
        drive(32'h100C, 5'd1, 2'd0, 2'd3);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("hit_no_mreq", bus.mem_req_valid, 1'b0);
        check("hit_ov_early", bus.out_valid, 1'b0);
        check("hit_cnt1", hitCnt, 3'd1);
        @(negedge clk);
        check("hit_out_valid", bus.out_valid, 1'b1);
        check("hit_rgba", bus.out_rgba, 32'h0C03013A);
        @(negedge clk);

        // Format change misses; memory and consumer backpressure
        bus.mem_req_ready = 1'b0;
        drive(32'h1000, 5'd2, 2'd1, 2'd2);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("fmt_miss", missCnt, 3'd2);
        for (int i = 0; i < 5; i++) begin
            check("bp_mreq_valid", bus.mem_req_valid, 1'b1);
            check("bp_mreq_addr", bus.mem_req_addr, 32'h1000);
            if (i == 4) bus.mem_req_ready = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        check("fmt_mwait_mreq", bus.mem_req_valid, 1'b0);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = BLK1;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        bus.out_ready     = 1'b0;
        @(negedge clk);
        check("fmt_out_valid", bus.out_valid, 1'b1);
        check("fmt_rgba", bus.out_rgba, 32'h9060026A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", bus.out_valid, 1'b1);
            check("bp_rgba_stable", bus.out_rgba, 32'h9060026A);
            check("bp_req_ready", bus.req_ready, 1'b0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", bus.out_valid, 1'b0);

        // Invalidate during MWAIT: result still returned, buffer left invalid
        drive(32'h2000, 5'd3, 2'd3, 2'd3);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("iv_miss", missCnt, 3'd3);
        @(negedge clk);
        inval = 1'b1;
        @(negedge clk);
        inval = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = BLK0;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("iv_rgba", bus.out_rgba, 32'h0F0003FA);
        @(negedge clk);
        drive(32'h2000, 5'd3, 2'd0, 2'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("iv_refetch", bus.mem_req_valid, 1'b1);
        check("iv_refetch_miss", missCnt, 3'd4);
        check("iv_hit_same", hitCnt, 3'd1);
        @(negedge clk);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = BLK1;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("iv_refetch_rgba", bus.out_rgba, 32'h00F0030A);
        @(negedge clk);

        // Invalidate together with a hit acceptance: hit uses old buffer
        drive(32'h2000, 5'd3, 2'd1, 2'd0);
        inval = 1'b1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        inval = 1'b0;
        check("ivh_no_mreq", bus.mem_req_valid, 1'b0);
        check("ivh_hit", hitCnt, 3'd2);
        @(negedge clk);
        check("ivh_rgba", bus.out_rgba, 32'h10E0034A);
        @(negedge clk);
        drive(32'h2000, 5'd3, 2'd0, 2'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("ivh_then_miss", bus.mem_req_valid, 1'b1);
        check("ivh_miss_cnt", missCnt, 3'd5);

        // Reset in MWAIT followed by a stray response
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mrst_req_ready", bus.req_ready, 1'b0);
        check("mrst_out_valid", bus.out_valid, 1'b0);
        check("mrst_hit", hitCnt, 3'd0);
        check("mrst_miss", missCnt, 3'd0);
        rst_n = 1'b1;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = BLK1;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        check("stray_out_valid", bus.out_valid, 1'b0);
        check("stray_req_ready", bus.req_ready, 1'b1);
        check("stray_mreq", bus.mem_req_valid, 1'b0);
        @(negedge clk);
        check("stray_out_valid2", bus.out_valid, 1'b0);
        drive(32'h2000, 5'd3, 2'd2, 2'd2);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("post_rst_miss", bus.mem_req_valid, 1'b1);
        check("post_rst_miss_cnt", missCnt, 3'd1);
        @(negedge clk);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = BLK0;
        @(negedge clk);
        bus.mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("post_rst_rgba", bus.out_rgba, 32'h0A0503AA);
        @(negedge clk);

        // Hit counter saturation at 7 (no wrap)
        for (int i = 0; i < 8; i++) begin
            drive(32'h2000, 5'd3, 2'd0, 2'd0);
            @(negedge clk);
            bus.req_valid = 1'b0;
            check("sat_no_mreq", bus.mem_req_valid, 1'b0);
            check("sat_hit_cnt", hitCnt, (i < 7) ? 3'(i + 1) : 3'd7);
            @(negedge clk);
            check("sat_rgba", bus.out_rgba, 32'h000F030A);
            @(negedge clk);
        end
        check("sat_miss_cnt", missCnt, 3'd1);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
